// File: rtl/pipe_datapath.sv
// Two-stage (IF / EX) RV32-style datapath driven by an external controller.
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   imem_addr/_rdata  : instruction fetch (address = PC, combinational read)
//   instr, ex_valid   : EX-stage instruction and its valid flag, to the controller
//   RegWrite..ALUControl : controller decode for the EX instruction
//   alu_zero          : ALU result equals zero
//   DataAddr, WriteData, ReadData, dmem_req, dmem_we, dmem_ready : data memory port
//   stall             : pipeline held this cycle (data access waiting on dmem_ready)
// Optional feature: define DATAPATH_PERF_EN to add perf_retired / perf_stall counters.
module pipe_datapath #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              ex_valid,
    input  logic              RegWrite,
    input  logic              ResultSrc,
    input  logic              ALUSrc,
    input  logic              PCSrc,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        ImmSrc,
    input  logic [2:0]        ALUControl,
    output logic              alu_zero,
    output logic [PC_W-1:0]   DataAddr,
    output logic [XLEN-1:0]   WriteData,
    input  logic [XLEN-1:0]   ReadData,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    output logic              stall
`ifdef DATAPATH_PERF_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned SH_W = $clog2(XLEN);
    localparam int unsigned NREG = 32;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ifex_instr_q, ifex_instr_d;
    logic [PC_W-1:0] ifex_pc_q, ifex_pc_d;
    logic            ifex_valid_q, ifex_valid_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext, rs1_val, rs2_val, src_b, alu_result, result;
    logic [SH_W-1:0] shamt;
    logic [4:0]      rd;
    logic            redirect, rf_we;
    logic            unused_opcode;

    assign rd            = ifex_instr_q[11:7];
    assign rs1_val       = rf_q[ifex_instr_q[19:15]];
    assign rs2_val       = rf_q[ifex_instr_q[24:20]];
    assign unused_opcode = ^ifex_instr_q[6:0];

    // Immediate decode, built at 32 bits then sign-extended to XLEN.
    always_comb begin
        imm32 = '0;
        case (ImmSrc)
            3'd0: imm32 = {{20{ifex_instr_q[31]}}, ifex_instr_q[31:20]};
            3'd1: imm32 = {{20{ifex_instr_q[31]}}, ifex_instr_q[31:25], ifex_instr_q[11:7]};
            3'd2: imm32 = {{19{ifex_instr_q[31]}}, ifex_instr_q[31], ifex_instr_q[7],
                           ifex_instr_q[30:25], ifex_instr_q[11:8], 1'b0};
            3'd3: imm32 = {ifex_instr_q[31:12], 12'b0};
            3'd4: imm32 = {{11{ifex_instr_q[31]}}, ifex_instr_q[31], ifex_instr_q[19:12],
                           ifex_instr_q[20], ifex_instr_q[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // ALU
    assign src_b = ALUSrc ? imm_ext : rs2_val;
    assign shamt = src_b[SH_W-1:0];
    always_comb begin
        alu_result = '0;
        case (ALUControl)
            3'b000: alu_result = rs1_val + src_b;
            3'b001: alu_result = rs1_val - src_b;
            3'b010: alu_result = rs1_val & src_b;
            3'b011: alu_result = rs1_val | src_b;
            3'b100: alu_result = rs1_val ^ src_b;
            3'b101: alu_result = XLEN'($signed(rs1_val) < $signed(src_b));
            3'b110: alu_result = rs1_val << shamt;
            default: alu_result = rs1_val >> shamt;
        endcase
    end

    assign alu_zero  = (alu_result == '0);
    assign DataAddr  = alu_result[PC_W-1:0];
    assign WriteData = rs2_val;
    assign result    = ResultSrc ? ReadData : alu_result;

    // Memory handshake; controller inputs only matter for a valid EX instruction.
    assign dmem_req  = ifex_valid_q & (MemRead | MemWrite);
    assign dmem_we   = ifex_valid_q & MemWrite;
    assign stall     = dmem_req & ~dmem_ready;
    assign redirect  = ifex_valid_q & PCSrc & ~stall;
    assign rf_we     = ifex_valid_q & RegWrite & ~stall & (rd != 5'd0);

    assign imem_addr = pc_q;
    assign instr     = ifex_instr_q;
    assign ex_valid  = ifex_valid_q;

    // Next-state for PC, IF/EX register and register file.
    always_comb begin
        pc_d         = pc_q;
        ifex_instr_d = ifex_instr_q;
        ifex_pc_d    = ifex_pc_q;
        ifex_valid_d = ifex_valid_q;
        rf_d         = rf_q;
        if (!stall) begin
            // Wrong-path fetch is still latched but marked invalid (one bubble).
            ifex_instr_d = imem_rdata;
            ifex_pc_d    = pc_q;
            ifex_valid_d = ~redirect;
            pc_d         = redirect ? (ifex_pc_q + imm_ext[PC_W-1:0])
                                    : (pc_q + PC_W'(4));
        end
        if (rf_we) begin
            rf_d[rd] = result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifex_instr_q <= '0;
            ifex_pc_q    <= '0;
            ifex_valid_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            ifex_instr_q <= ifex_instr_d;
            ifex_pc_q    <= ifex_pc_d;
            ifex_valid_q <= ifex_valid_d;
            rf_q         <= rf_d;
        end
    end

`ifdef DATAPATH_PERF_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Free-running event counters, wrapping naturally at 2^32.
    always_comb begin
        perf_retired_d = perf_retired_q + 32'(ifex_valid_q & ~stall);
        perf_stall_d   = perf_stall_q + 32'(stall);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: small program, behavioural controller and
// memories, store scoreboard plus direct pipeline/handshake checks.
module tb_pipe_datapath;

    logic        clk, reset;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata, instr;
    logic        ex_valid;
    logic        RegWrite, ResultSrc, ALUSrc, PCSrc, MemRead, MemWrite;
    logic [2:0]  ImmSrc, ALUControl;
    logic        alu_zero;
    logic [15:0] DataAddr;
    logic [31:0] WriteData, ReadData;
    logic        dmem_req, dmem_we, dmem_ready, stall;
`ifdef DATAPATH_PERF_EN
    logic [31:0] perf_retired, perf_stall;
`endif

    pipe_datapath #(.XLEN(32), .PC_W(16), .RESET_PC(16'h0040)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .ex_valid(ex_valid),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrc(ALUSrc),
        .PCSrc(PCSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .alu_zero(alu_zero), .DataAddr(DataAddr), .WriteData(WriteData),
        .ReadData(ReadData), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .stall(stall)
`ifdef DATAPATH_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] imem [64];
    logic [31:0] dmem [16];
    int          lat_cfg;
    int          wait_q;
    logic [15:0] sb_addr [$];
    logic [31:0] sb_data [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Encoders
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[11:5], 5'(rs2), 5'(rs1), 3'b010, iv[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[12], iv[10:5], 5'(rs2), 5'(rs1), 3'b000, iv[4:1], iv[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[20], iv[10:1], iv[11], iv[19:12], 5'(rd), 7'b1101111};
    endfunction

    // Behavioural controller: decodes instr regardless of ex_valid.
    always_comb begin
        RegWrite = 1'b0; ResultSrc = 1'b0; ALUSrc = 1'b0; PCSrc = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; ImmSrc = 3'd0; ALUControl = 3'b000;
        case (instr[6:0])
            7'b0010011: begin RegWrite = 1'b1; ALUSrc = 1'b1; end
            7'b0110011: begin
                RegWrite = 1'b1;
                case (instr[14:12])
                    3'b000:  ALUControl = instr[30] ? 3'b001 : 3'b000;
                    3'b111:  ALUControl = 3'b010;
                    3'b110:  ALUControl = 3'b011;
                    3'b100:  ALUControl = 3'b100;
                    3'b010:  ALUControl = 3'b101;
                    3'b001:  ALUControl = 3'b110;
                    default: ALUControl = 3'b111;
                endcase
            end
            7'b0000011: begin RegWrite = 1'b1; ResultSrc = 1'b1; ALUSrc = 1'b1; MemRead = 1'b1; end
            7'b0100011: begin ALUSrc = 1'b1; ImmSrc = 3'd1; MemWrite = 1'b1; end
            7'b1100011: begin ImmSrc = 3'd2; ALUControl = 3'b001; PCSrc = alu_zero; end
            7'b1101111: begin ImmSrc = 3'd4; PCSrc = 1'b1; end
            default: ;
        endcase
    end

    // Memories: instruction ROM, data RAM with configurable load latency.
    always_comb imem_rdata = imem[imem_addr[7:2]];
    always_comb ReadData   = dmem[DataAddr[5:2]];
    always_comb dmem_ready = dmem_req && (MemWrite || wait_q >= lat_cfg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_q <= 0;
        else if (dmem_req && !dmem_ready) wait_q <= wait_q + 1;
        else wait_q <= 0;
    end

    always @(posedge clk) begin
        if (!reset && dmem_req && dmem_we && dmem_ready) dmem[DataAddr[5:2]] <= WriteData;
    end

    // Store monitor: pop scoreboard entry when a store completes.
    always @(negedge clk) begin
        if (!reset && dmem_req && dmem_we && dmem_ready) begin
            n_cmp++;
            assert (sb_addr.size() != 0) else begin
                n_fail++;
                $error("FAIL store_unexpected: observed addr %h data %h, required none", DataAddr, WriteData);
            end
            if (sb_addr.size() != 0) begin
                logic [15:0] ea;
                logic [31:0] ed;
                ea = sb_addr.pop_front();
                ed = sb_data.pop_front();
                n_cmp++;
                assert (DataAddr === ea && WriteData === ed) else begin
                    n_fail++;
                    $error("FAIL store: observed addr %h data %h, required addr %h data %h",
                           DataAddr, WriteData, ea, ed);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ex(input logic [31:0] w, input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (ex_valid === 1'b1 && instr === w) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic put(input int pc, input logic [31:0] w);
        imem[pc[7:2]] = w;
    endtask

    task automatic expect_store(input int a, input logic [31:0] d);
        sb_addr.push_back(16'(a));
        sb_data.push_back(d);
    endtask

    logic [31:0] w_add2, w_add3, w_sub4, w_lw5, w_beq64, w_beq10, w_addi7, w_jal1c, w_lw16;

    initial begin
        reset = 1'b1;
        lat_cfg = 3;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        dmem[2] = 32'h1234_5678;

        w_add2  = enc_r(7'h00, 1, 1, 3'b000, 2);
        w_add3  = enc_r(7'h00, 0, 0, 3'b000, 3);
        w_sub4  = enc_r(7'h20, 1, 1, 3'b000, 4);
        w_lw5   = enc_i(8, 0, 3'b010, 5, 7'b0000011);
        w_beq64 = enc_b(-84, 0, 0);
        w_beq10 = enc_b(8, 0, 0);
        w_addi7 = enc_i(99, 0, 3'b000, 7, 7'b0010011);
        w_jal1c = enc_j(84, 0);
        w_lw16  = enc_i(0, 0, 3'b010, 16, 7'b0000011);

        put(32'h40, enc_i(5, 0, 3'b000, 1, 7'b0010011));
        put(32'h44, w_add2);
        put(32'h48, enc_s(0, 2, 0));                    expect_store(0, 32'd10);
        put(32'h4C, enc_i(7, 0, 3'b000, 0, 7'b0010011));
        put(32'h50, w_add3);
        put(32'h54, enc_s(4, 3, 0));                    expect_store(4, 32'd0);
        put(32'h58, w_sub4);
        put(32'h5C, w_lw5);
        put(32'h60, enc_s(12, 5, 0));                   expect_store(12, 32'h1234_5678);
        put(32'h64, w_beq64);
        put(32'h68, enc_i(1, 0, 3'b000, 6, 7'b0010011));
        put(32'h10, w_beq10);
        put(32'h14, w_addi7);
        put(32'h18, enc_s(16, 7, 0));                   expect_store(16, 32'd0);
        put(32'h1C, w_jal1c);
        put(32'h20, enc_i(1, 0, 3'b000, 15, 7'b0010011));
        put(32'h70, enc_i(-3, 0, 3'b000, 8, 7'b0010011));
        put(32'h74, enc_r(7'h00, 1, 8, 3'b010, 9));
        put(32'h78, enc_r(7'h00, 1, 8, 3'b101, 10));
        put(32'h7C, enc_r(7'h00, 1, 1, 3'b001, 11));
        put(32'h80, enc_r(7'h00, 1, 8, 3'b111, 12));
        put(32'h84, enc_r(7'h00, 1, 8, 3'b110, 13));
        put(32'h88, enc_r(7'h00, 1, 8, 3'b100, 14));
        put(32'h8C, enc_s(20, 9, 0));                   expect_store(20, 32'd1);
        put(32'h90, enc_s(24, 10, 0));                  expect_store(24, 32'h07FF_FFFF);
        put(32'h94, enc_s(28, 11, 0));                  expect_store(28, 32'd160);
        put(32'h98, enc_s(32, 12, 0));                  expect_store(32, 32'd5);
        put(32'h9C, enc_s(36, 13, 0));                  expect_store(36, 32'hFFFF_FFFD);
        put(32'hA0, enc_s(40, 14, 0));                  expect_store(40, 32'hFFFF_FFF8);
        put(32'hA4, enc_s(44, 15, 0));                  expect_store(44, 32'd0);
        put(32'hA8, w_lw16);
        put(32'hAC, enc_j(0, 0));

        // Reset state
        step();
        check("rst_pc", 32'(imem_addr), 32'h40);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
`ifdef DATAPATH_PERF_EN
        check("rst_perf_retired", perf_retired, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        step();
        check("first_pc", 32'(imem_addr), 32'h44);
        check("first_ex_valid", 32'(ex_valid), 32'd1);
        check("first_instr", instr, enc_i(5, 0, 3'b000, 1, 7'b0010011));

        // Back-to-back dependency: add x2,x1,x1 right after addi x1
        step();
        check("b2b_instr", instr, w_add2);
        check("b2b_result", 32'(DataAddr), 32'd10);
        check("b2b_stall", 32'(stall), 32'd0);

        wait_ex(w_add3, "reach_add_x0");
        check("x0_reads_zero", 32'(DataAddr), 32'd0);
        wait_ex(w_sub4, "reach_sub");
        check("sub_alu_zero", 32'(alu_zero), 32'd1);

        // Load with three not-ready cycles
        wait_ex(w_lw5, "reach_lw");
        for (int i = 0; i < 3; i++) begin
            check("lw_stall", 32'(stall), 32'd1);
            check("lw_pc_frozen", 32'(imem_addr), 32'h60);
            check("lw_req", 32'(dmem_req), 32'd1);
            step();
        end
        check("lw_ready_no_stall", 32'(stall), 32'd0);
        check("lw_ready_pc", 32'(imem_addr), 32'h60);
        step();
        check("lw_after_pc", 32'(imem_addr), 32'h64);
        lat_cfg = 200;

        // Taken branches: backward to 0x10, then 0x10 -> 0x18
        wait_ex(w_beq64, "reach_beq64");
        check("beq64_if_pc", 32'(imem_addr), 32'h68);
        step();
        check("beq64_target", 32'(imem_addr), 32'h10);
        check("beq64_bubble", 32'(ex_valid), 32'd0);
        step();
        check("beq10_ex", instr, w_beq10);
        step();
        check("beq10_target", 32'(imem_addr), 32'h18);
        check("beq10_bubble", 32'(ex_valid), 32'd0);
        check("beq10_flushed_instr", instr, w_addi7);
        check("bubble_no_req", 32'(dmem_req), 32'd0);

        // Jump (J immediate)
        wait_ex(w_jal1c, "reach_jal");
        step();
        check("jal_target", 32'(imem_addr), 32'h70);
        check("jal_bubble", 32'(ex_valid), 32'd0);

        // Reset in the middle of a stalled load
        wait_ex(w_lw16, "reach_lw16");
        step();
        step();
        check("lw16_stall", 32'(stall), 32'd1);
        check("lw16_pc_frozen", 32'(imem_addr), 32'hAC);
        check("sb_drained", 32'(sb_addr.size()), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_pc", 32'(imem_addr), 32'h40);
        check("midrst_ex_valid", 32'(ex_valid), 32'd0);
`ifdef DATAPATH_PERF_EN
        check("midrst_perf_retired", perf_retired, 32'd0);
        check("midrst_perf_stall", perf_stall, 32'd0);
`endif
        lat_cfg = 0;
        step();
        @(negedge clk);
        reset = 1'b0;
        check("rerst_fetch", 32'(imem_addr), 32'h40);
        step();
        check("rerst_pc", 32'(imem_addr), 32'h44);
        check("rerst_ex_valid", 32'(ex_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data/register width (≥32, power of 2).
REQ-002 SHALL provide parameter PC_W, default 16, program-counter and data-address width.
REQ-003 SHALL provide parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have one clock and an asynchronous, active-high reset. Ports, in order:
- clk  in  1  sole clock, rising edge
- reset  in  1  async active-high reset
- imem_addr  out  PC_W  fetch address (= PC)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- instr  out  32  EX-stage instruction, to controller
- ex_valid  out  1  EX stage holds a real instruction
- RegWrite, ResultSrc, ALUSrc, PCSrc, MemRead, MemWrite  in  1 each  controller controls for EX instruction
- ImmSrc  in  3  immediate format
- ALUControl  in  3  ALU operation
- alu_zero  out  1  ALU result == 0
- DataAddr  out  PC_W  alu_result[PC_W-1:0]
- WriteData  out  XLEN  rs2 value
- ReadData  in  XLEN  load data
- dmem_req  out  1  data access request
- dmem_we  out  1  store qualifier
- dmem_ready  in  1  access completes this cycle
- stall  out  1  pipeline held this cycle

Function
REQ-005 SHALL be a 2-stage pipeline: IF (PC, fetch) and EX (decode via external controller, regfile read, ALU, memory, writeback); IF/EX register holds {instr, pc, valid}.
REQ-006 SHALL contain 32 x XLEN register file, two combinational reads (instr[19:15], instr[24:20]), one write (instr[11:7]); x0 reads 0, writes ignored.
REQ-007 SHALL, each cycle with stall=0 and no redirect, latch IF/EX <= {imem_rdata, PC, 1} and PC <= PC+4 (modulo 2^PC_W).
REQ-008 SHALL sign-extend immediates to XLEN: ImmSrc 0=I, 1=S, 2=B, 3=U, 4=J; 5-7 yield 0.
REQ-009 SHALL implement ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl; shift amount = srcB[log2(XLEN)-1:0]; srcB = ALUSrc ? imm : rs2.
REQ-010 SHALL, when ex_valid & PCSrc & !stall, set PC <= ex_pc + imm and clear IF/EX valid next cycle (one-bubble flush).
REQ-011 SHALL assert dmem_req = ex_valid & (MemRead|MemWrite), dmem_we = ex_valid & MemWrite.
REQ-012 SHALL assert stall = dmem_req & !dmem_ready; while stalled PC, IF/EX and register file hold.
REQ-013 SHALL write Result (ResultSrc ? ReadData : alu_result) on the rising edge where ex_valid & RegWrite & !stall & rd≠0.
REQ-014 SHALL ignore all controller inputs when ex_valid=0 (no write, no request, no redirect).
REQ-015 SHALL give stall priority over branch redirect; redirect takes effect on the edge dmem_ready is seen.
REQ-016 SHALL need no hazard logic: read and write both occur in EX, write visible to the next instruction.

Reset
REQ-017 SHALL on reset asynchronously set PC=RESET_PC, ex_valid=0, IF/EX instr=0, all registers=0, counters=0; dmem_req, dmem_we, stall read 0 during reset.
REQ-018 SHALL abort any in-flight stalled access on reset; first fetch after release is RESET_PC.

Configuration
REQ-019 SHALL, with DATAPATH_PERF_EN defined, add outputs perf_retired (32) and perf_stall (32), counting instructions retired (ex_valid & !stall) and stalled cycles, wrapping at 2^32.
REQ-020 SHALL, without DATAPATH_PERF_EN, omit those ports and counters entirely.

Verification
REQ-021 Reset with RESET_PC=0x40 -> imem_addr=0x40, ex_valid=0; after one edge imem_addr=0x44, ex_valid=1.
REQ-022 addi x1,x0,5 then add x2,x1,x1 back-to-back -> x2=10, no stall.
REQ-023 Taken branch at pc 0x10, imm=+8 -> next imem_addr=0x18, following cycle ex_valid=0, instruction at 0x14 never writes.
REQ-024 lw with dmem_ready low 3 cycles -> stall=1 for 3 cycles, PC frozen, rd written once with ReadData on ready cycle.
REQ-025 Write to x0 then read x0 -> reads 0; sub with equal operands -> alu_zero=1.
REQ-026 Reset asserted mid-stall -> dmem_req drops immediately, PC=RESET_PC; with DATAPATH_PERF_EN both counters read 0.
